// File: rtl/roots_stream_serializer.sv
// rtl/roots_stream_serializer.sv - snapshots the decoder roots vector on round completion
// and streams a header word plus one {k,i,j} word per PU over a valid/ready link.
module roots_stream_serializer #(
    parameter int CODE_DISTANCE_X     = 5,
    parameter int CODE_DISTANCE_Z     = 4,
    parameter int MEASUREMENT_ROUNDS  = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
    parameter int PU_COUNT            = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
    parameter int PER_DIMENSION_WIDTH = $clog2(MEASUREMENT_ROUNDS),
    parameter int ADDRESS_WIDTH       = 3 * PER_DIMENSION_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              result_valid,
    input  logic                              deadlock,
    input  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots,
    output logic [31:0]                       out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic [30:0]                       test_id,
    output logic                              overflow
);

    localparam int PDW   = PER_DIMENSION_WIDTH;
    localparam int IDX_W = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PU_COUNT - 1);

    generate
        if (PER_DIMENSION_WIDTH > 8) begin : g_pdw_check
            $error("PER_DIMENSION_WIDTH must not exceed 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [ADDRESS_WIDTH*PU_COUNT-1:0] snap_q, snap_d;
    logic                              dl_q, dl_d;
    logic                              trigger_q;
    logic [30:0]                       test_id_q, test_id_d;
    logic                              overflow_q, overflow_d;

    logic                              trig;
    logic                              trig_edge;
    logic [ADDRESS_WIDTH-1:0]          entry;

    assign trig      = result_valid | deadlock;
    assign trig_edge = trig & ~trigger_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            snap_q     <= '0;
            dl_q       <= 1'b0;
            trigger_q  <= 1'b0;
            test_id_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            dl_q       <= dl_d;
            trigger_q  <= trig;
            test_id_q  <= test_id_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        dl_d       = dl_q;
        test_id_d  = test_id_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (trig_edge) begin
                    snap_d  = roots;
                    dl_d    = deadlock;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (out_ready) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d   = IDLE;
                        idx_d     = '0;
                        test_id_d = test_id_q + 31'd1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Any new round while a packet is in flight is lost; remember that it happened.
        if (trig_edge && (state_q != IDLE)) begin
            overflow_d = 1'b1;
        end
    end

    assign entry = snap_q[ADDRESS_WIDTH*idx_q +: ADDRESS_WIDTH];

    always_comb begin
        out_data = '0;
        case (state_q)
            HEADER: out_data = {dl_q, test_id_q};
            STREAM: begin
                out_data[PDW-1:0]   = entry[PDW-1:0];
                out_data[8 +: PDW]  = entry[PDW +: PDW];
                out_data[16 +: PDW] = entry[2*PDW +: PDW];
            end
            default: out_data = '0;
        endcase
    end

    assign out_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign test_id   = test_id_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_roots_stream_serializer.sv
// tb/tb_roots_stream_serializer.sv - scoreboard bench for roots_stream_serializer
module tb_roots_stream_serializer;

    localparam int DX  = 5;
    localparam int DZ  = 4;
    localparam int MR  = 5;
    localparam int PU  = DX * DZ * MR;
    localparam int PDW = 3;
    localparam int AW  = 3 * PDW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              result_valid = 1'b0;
    logic              deadlock = 1'b0;
    logic [AW*PU-1:0]  roots = '0;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic [30:0]       test_id;
    logic              overflow;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    bit chk_const = 1'b0;
    bit have_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] exp_q[$];

    roots_stream_serializer #(
        .CODE_DISTANCE_X(DX),
        .CODE_DISTANCE_Z(DZ)
    ) dut (
        .clk(clk),
        .reset(reset),
        .result_valid(result_valid),
        .deadlock(deadlock),
        .roots(roots),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .test_id(test_id),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int n);
        int k, i, j;
        k = n / (DX * DZ);
        i = (n % (DX * DZ)) / DZ;
        j = n % DZ;
        return (k << 16) | (i << 8) | j;
    endfunction

    task automatic set_roots_own;
        for (int n = 0; n < PU; n++) begin
            int k, i, j;
            k = n / (DX * DZ);
            i = (n % (DX * DZ)) / DZ;
            j = n % DZ;
            roots[AW*n +: AW] = {3'(k), 3'(i), 3'(j)};
        end
    endtask

    task automatic push_packet(input logic [31:0] hdr);
        exp_q.push_back(hdr);
        for (int n = 0; n < PU; n++) exp_q.push_back(word_of(n));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_cycle(input bit rdy);
        logic [31:0] e;
        @(negedge clk);
        out_ready = rdy;
        if (have_prev) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", out_data, prev_data);
        end
        have_prev = 1'b0;
        if (out_valid === 1'b1) begin
            if (rdy) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL extra_word observed=%h expected=none", out_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word", out_data, e);
                end
                if (chk_const && acc_cnt == 8)   check("word7", out_data, 32'h00000103);
                if (chk_const && acc_cnt == 100) check("word99", out_data, 32'h00040403);
                acc_cnt++;
            end else begin
                have_prev = 1'b1;
                prev_data = out_data;
            end
        end
    endtask

    task automatic drain(input int max_acc, input bit rnd, output int cyc);
        cyc = 0;
        while (exp_q.size() > 0 && acc_cnt < max_acc && cyc < 3000) begin
            do_cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            cyc++;
        end
        total++;
        assert (cyc < 3000) else begin
            bad++;
            $error("FAIL drain_timeout observed=%0d expected<3000", cyc);
        end
    endtask

    task automatic check_idle(input string tag, input logic [30:0] tid, input logic ovf);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_test_id"}, {1'b0, test_id}, {1'b0, tid});
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ovf});
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        // Reset state
        repeat (3) @(negedge clk);
        check_idle("reset", 31'd0, 1'b0);
        check("reset_data", out_data, 32'd0);
        reset = 1'b0;

        // Basic packet at full throughput
        set_roots_own();
        push_packet(32'h00000000);
        acc_cnt = 0;
        chk_const = 1'b1;
        result_valid = 1'b1;
        do_cycle(1'b1);
        result_valid = 1'b0;
        drain(PU + 1, 1'b0, cyc);
        chk_const = 1'b0;
        check("throughput_cycles", 32'(cyc + 1), 32'(PU + 1));
        check("accepts", 32'(acc_cnt), 32'(PU + 1));
        do_cycle(1'b1);
        check_idle("pkt1", 31'd1, 1'b0);

        // Random backpressure
        push_packet(32'h00000001);
        acc_cnt = 0;
        result_valid = 1'b1;
        do_cycle(1'b0);
        result_valid = 1'b0;
        drain(PU + 1, 1'b1, cyc);
        do_cycle(1'b1);
        check("rand_accepts", 32'(acc_cnt), 32'(PU + 1));
        check_idle("pkt2", 31'd2, 1'b0);

        // Deadlock round after fresh reset
        do_reset();
        push_packet(32'h80000000);
        acc_cnt = 0;
        deadlock = 1'b1;
        do_cycle(1'b1);
        deadlock = 1'b0;
        drain(PU + 1, 1'b0, cyc);
        do_cycle(1'b1);
        check_idle("dl", 31'd1, 1'b0);

        // Overflow and snapshot isolation
        push_packet(32'h00000001);
        acc_cnt = 0;
        result_valid = 1'b1;
        do_cycle(1'b1);
        result_valid = 1'b0;
        repeat (4) do_cycle(1'b1);
        result_valid = 1'b1;
        do_cycle(1'b1);
        result_valid = 1'b0;
        roots = '1;
        drain(PU + 1, 1'b0, cyc);
        repeat (20) do_cycle(1'b1);
        check_idle("ovf", 31'd2, 1'b1);

        // Reset mid-packet
        set_roots_own();
        push_packet(32'h00000002);
        acc_cnt = 0;
        result_valid = 1'b1;
        do_cycle(1'b1);
        result_valid = 1'b0;
        drain(40, 1'b0, cyc);
        reset = 1'b1;
        @(negedge clk);
        check_idle("midrst", 31'd0, 1'b0);
        check("midrst_data", out_data, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (5) do_cycle(1'b1);
        push_packet(32'h00000000);
        acc_cnt = 0;
        result_valid = 1'b1;
        do_cycle(1'b1);
        result_valid = 1'b0;
        drain(PU + 1, 1'b0, cyc);
        do_cycle(1'b1);
        check_idle("postrst", 31'd1, 1'b0);

        // Trigger held through reset release and for 300 cycles
        reset = 1'b1;
        result_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_packet(32'h00000000);
        acc_cnt = 0;
        repeat (300) do_cycle(1'b1);
        check("hold_accepts", 32'(acc_cnt), 32'(PU + 1));
        result_valid = 1'b0;
        repeat (3) do_cycle(1'b1);
        push_packet(32'h00000001);
        acc_cnt = 0;
        result_valid = 1'b1;
        do_cycle(1'b1);
        result_valid = 1'b0;
        drain(PU + 1, 1'b0, cyc);
        do_cycle(1'b1);
        check_idle("hold2", 31'd2, 1'b0);

        // Simultaneous result_valid and deadlock edge
        push_packet(32'h80000002);
        acc_cnt = 0;
        result_valid = 1'b1;
        deadlock = 1'b1;
        do_cycle(1'b1);
        result_valid = 1'b0;
        deadlock = 1'b0;
        drain(PU + 1, 1'b0, cyc);
        repeat (5) do_cycle(1'b1);
        check_idle("both", 31'd3, 1'b0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
